// File: rtl/spi_shift_port.sv
// spi_shift_port: full-duplex serial shift port. It synchronises raw sclk,
// cs_n and mosi pins, detects sclk/cs_n edges in the clk domain, and
// exchanges one W-bit word per frame under a two-state framing FSM.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   sclk_in, cs_n_in    raw asynchronous serial clock / chip select (low)
//   mosi_in             raw asynchronous serial data in
//   lsb_first           bit order, latched at frame start
//   sample_falling      0: sample on rise, shift on fall; 1: reverse
//   parallel_load       load parallel_data_in as the tx word (IDLE only)
//   parallel_data_in    word to transmit
//   parallel_data_out   last completely received word
//   miso_out            serial data out
//   frame_done          one-cycle pulse per completed word
//   busy                high while ACTIVE
//   bit_count           bits received in the current word
//   load_err            one-cycle pulse when a load is rejected
//
// state  | meaning
// IDLE   | cs_n high; tx word may be loaded, miso shows first tx bit
// ACTIVE | cs_n low; shifting rx/tx on sclk edges, frames may repeat
module spi_shift_port #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sclk_in,
    input  logic                   cs_n_in,
    input  logic                   mosi_in,
    input  logic                   lsb_first,
    input  logic                   sample_falling,
    input  logic                   parallel_load,
    input  logic [W-1:0]           parallel_data_in,
    output logic [W-1:0]           parallel_data_out,
    output logic                   miso_out,
    output logic                   frame_done,
    output logic                   busy,
    output logic [$clog2(W+1)-1:0] bit_count,
    output logic                   load_err
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d, mosi_dly_q, mosi_dly_d;
    logic sclk_rise_q, sclk_rise_d, sclk_fall_q, sclk_fall_d;
    logic cs_fall_q, cs_fall_d, cs_rise_q, cs_rise_d;

    state_t         state_q, state_d;
    logic [W-1:0]   tx_q, tx_d, rx_q, rx_d, pdo_q, pdo_d;
    logic [CW-1:0]  bit_count_q, bit_count_d;
    logic           frame_done_q, frame_done_d, load_err_q, load_err_d;
    logic           lsb_l_q, lsb_l_d, sfall_l_q, sfall_l_d;

    logic           sample_edge, shift_edge, miso_lsb;
    logic [W-1:0]   rx_next, tx_rot;

    // Front end: mosi gets an extra delay stage so the bit used at a sample
    // pulse is the one present at the same raw time as the sclk edge.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
        mosi_dly_d  = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
        sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_dly_q;
        cs_rise_d   = cs_sync_q[SYNC_STAGES-1] & ~cs_dly_q;
        cs_fall_d   = ~cs_sync_q[SYNC_STAGES-1] & cs_dly_q;
    end

    assign sample_edge = sfall_l_q ? sclk_fall_q : sclk_rise_q;
    assign shift_edge  = sfall_l_q ? sclk_rise_q : sclk_fall_q;
    assign tx_rot      = lsb_l_q ? {tx_q[0], tx_q[W-1:1]} : {tx_q[W-2:0], tx_q[W-1]};
    assign rx_next     = lsb_l_q ? {mosi_dly_q, rx_q[W-1:1]} : {rx_q[W-2:0], mosi_dly_q};

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        pdo_d        = pdo_q;
        bit_count_d  = bit_count_q;
        lsb_l_d      = lsb_l_q;
        sfall_l_d    = sfall_l_q;
        frame_done_d = 1'b0;
        load_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (parallel_load) tx_d = parallel_data_in;
                if (cs_fall_q) begin
                    lsb_l_d     = lsb_first;
                    sfall_l_d   = sample_falling;
                    bit_count_d = '0;
                    rx_d        = '0;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (parallel_load) load_err_d = 1'b1;
                if (sample_edge) begin
                    if (bit_count_q == CW'(W - 1)) begin
                        pdo_d        = rx_next;
                        frame_done_d = 1'b1;
                        bit_count_d  = '0;
                        rx_d         = '0;
                        // Only W-1 shifts happen inside a word; the last one is
                        // folded in here so tx is back to the original word.
                        tx_d         = tx_rot;
                    end else begin
                        rx_d        = rx_next;
                        bit_count_d = bit_count_q + CW'(1);
                    end
                end else if (shift_edge && bit_count_q != '0) begin
                    // A shift edge before the first sample of a word would
                    // skip bit 0, so it is ignored.
                    tx_d = tx_rot;
                end
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    bit_count_d = '0;
                    rx_d        = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_dly_q   <= 1'b0;
            cs_dly_q     <= 1'b1;
            mosi_dly_q   <= 1'b0;
            sclk_rise_q  <= 1'b0;
            sclk_fall_q  <= 1'b0;
            cs_rise_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            pdo_q        <= '0;
            bit_count_q  <= '0;
            frame_done_q <= 1'b0;
            load_err_q   <= 1'b0;
            lsb_l_q      <= 1'b0;
            sfall_l_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_dly_q   <= sclk_dly_d;
            cs_dly_q     <= cs_dly_d;
            mosi_dly_q   <= mosi_dly_d;
            sclk_rise_q  <= sclk_rise_d;
            sclk_fall_q  <= sclk_fall_d;
            cs_rise_q    <= cs_rise_d;
            cs_fall_q    <= cs_fall_d;
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            pdo_q        <= pdo_d;
            bit_count_q  <= bit_count_d;
            frame_done_q <= frame_done_d;
            load_err_q   <= load_err_d;
            lsb_l_q      <= lsb_l_d;
            sfall_l_q    <= sfall_l_d;
        end
    end

    // In IDLE the bit order follows the live input so miso is ready early.
    assign miso_lsb          = (state_q == ACTIVE) ? lsb_l_q : lsb_first;
    assign miso_out          = miso_lsb ? tx_q[0] : tx_q[W-1];
    assign busy              = (state_q == ACTIVE);
    assign bit_count         = bit_count_q;
    assign parallel_data_out = pdo_q;
    assign frame_done        = frame_done_q;
    assign load_err          = load_err_q;

endmodule

// File: tb/tb_spi_shift_port.sv
// Bench for spi_shift_port: raw pins are driven in clk-aligned steps, each pin
// change becomes a word-level event applied to a behavioural model after the
// fixed synchroniser latency, and outputs are compared every cycle.
module tb_spi_shift_port;
    localparam int W   = 8;
    localparam int S   = 2;
    localparam int CW  = $clog2(W + 1);
    localparam int LAT = S + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
    logic lsb_first = 1'b0, sample_falling = 1'b0, parallel_load = 1'b0;
    logic [W-1:0]  parallel_data_in = '0;
    logic [W-1:0]  parallel_data_out;
    logic          miso_out, frame_done, busy, load_err;
    logic [CW-1:0] bit_count;

    always #5 clk = ~clk;

    spi_shift_port #(.W(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .cs_n_in(cs_n_in),
        .mosi_in(mosi_in), .lsb_first(lsb_first), .sample_falling(sample_falling),
        .parallel_load(parallel_load), .parallel_data_in(parallel_data_in),
        .parallel_data_out(parallel_data_out), .miso_out(miso_out),
        .frame_done(frame_done), .busy(busy), .bit_count(bit_count),
        .load_err(load_err));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef enum int {EV_RISE, EV_FALL, EV_CSF, EV_CSR, EV_LOAD} ev_kind_t;
    typedef struct {
        int unsigned  at;
        ev_kind_t     kind;
        logic [W-1:0] data;
        logic         m0;
        logic         m1;
    } ev_t;
    ev_t evq[$];
    ev_t keep_q[$];

    // Word-level model of the port.
    bit           m_active = 0, m_lsb = 0, m_sfall = 0, m_tx_known = 1;
    bit           m_done = 0, m_lerr = 0;
    logic [W-1:0] m_tx = '0, m_rx = '0, m_pdo = '0;
    int           m_cnt = 0;
    int           done_seen = 0, lerr_seen = 0;
    int unsigned  last_done_cyc = 0, last_rise_cyc = 0;
    logic         miso_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_tx = '0; m_rx = '0; m_pdo = '0; m_cnt = 0;
        m_tx_known = 1; m_done = 0; m_lerr = 0;
    endtask

    task automatic apply_ev(input ev_t e);
        case (e.kind)
            EV_LOAD: begin
                if (m_active) m_lerr = 1;
                else begin m_tx = e.data; m_tx_known = 1; end
            end
            EV_CSF: if (!m_active) begin
                m_active = 1; m_lsb = e.m0; m_sfall = e.m1; m_cnt = 0; m_rx = '0;
            end
            EV_CSR: if (m_active) begin
                if (m_cnt != 0) m_tx_known = 0;
                m_active = 0; m_cnt = 0; m_rx = '0;
            end
            default: begin
                if (m_active && ((e.kind == EV_RISE) != m_sfall)) begin
                    // bit k of the word is on miso when the k-th sample is taken
                    if (m_tx_known)
                        check("miso_at_sample", 32'(miso_out),
                              32'(m_lsb ? m_tx[m_cnt] : m_tx[W-1-m_cnt]));
                    miso_log.push_back(miso_out);
                    if (m_lsb) m_rx = m_rx | (W'(e.data[0]) << m_cnt);
                    else       m_rx = (m_rx << 1) | W'(e.data[0]);
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_pdo = m_rx; m_done = 1; m_cnt = 0; m_rx = '0;
                    end
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active));
        check("bit_count", 32'(bit_count), 32'(m_cnt));
        check("data_out", 32'(parallel_data_out), 32'(m_pdo));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("load_err", 32'(load_err), 32'(m_lerr));
        if (!m_active && m_tx_known)
            check("miso_idle", 32'(miso_out), 32'(lsb_first ? m_tx[0] : m_tx[W-1]));
        if (frame_done === 1'b1) begin done_seen++; last_done_cyc = cyc; end
        if (load_err === 1'b1) lerr_seen++;
        m_done = 0;
        m_lerr = 0;
        if (reset) begin
            model_reset();
            evq.delete();
        end else begin
            keep_q.delete();
            foreach (evq[i]) if (evq[i].at == cyc + 1 && evq[i].kind == EV_LOAD) apply_ev(evq[i]);
            foreach (evq[i]) begin
                if (evq[i].at == cyc + 1) begin
                    if (evq[i].kind != EV_LOAD) apply_ev(evq[i]);
                end else keep_q.push_back(evq[i]);
            end
            evq = keep_q;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input ev_kind_t k, input logic [W-1:0] d, input int unsigned lat);
        ev_t e;
        e.at = cyc + lat; e.kind = k; e.data = d; e.m0 = lsb_first; e.m1 = sample_falling;
        evq.push_back(e);
    endtask

    task automatic set_sclk(input logic v);
        if (sclk_in !== v) begin
            sclk_in = v;
            if (v) last_rise_cyc = cyc;
            push(v ? EV_RISE : EV_FALL, W'(mosi_in), LAT);
        end
    endtask

    task automatic set_cs(input logic v);
        cs_n_in = v;
        push(v ? EV_CSR : EV_CSF, '0, LAT);
    endtask

    task automatic do_load(input logic [W-1:0] d);
        parallel_data_in = d;
        parallel_load = 1'b1;
        push(EV_LOAD, d, 1);
        tick(1);
        parallel_load = 1'b0;
    endtask

    task automatic start_frame(input logic lsb, input logic sf, input logic [W-1:0] tx);
        lsb_first = lsb; sample_falling = sf;
        do_load(tx);
        tick(3);
        set_cs(1'b0);
        tick(10);
    endtask

    task automatic end_frame(input int hp);
        tick(hp);
        set_cs(1'b1);
        tick(12);
    endtask

    // mosi changes 2 cycles after the previous fall so it is stable across
    // the synchroniser window of both sclk edges.
    task automatic send_word(input logic [W-1:0] word, input int nbits, input logic lsb,
                             input int hp, input int bad_at, input logic [W-1:0] bad);
        for (int i = 0; i < nbits; i++) begin
            tick(2);
            mosi_in = lsb ? word[i] : word[W-1-i];
            if (i == bad_at) begin do_load(bad); tick(hp - 3); end
            else tick(hp - 2);
            set_sclk(1'b1);
            tick(hp);
            set_sclk(1'b0);
        end
    endtask

    function automatic logic [2*W-1:0] pack_log();
        logic [2*W-1:0] v = '0;
        foreach (miso_log[i]) v = {v[2*W-2:0], miso_log[i]};
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0;
        logic [W-1:0] rw, bw, txw;
        logic lsb, sf;
        int hp, nw, nb, bad_at;

        // Reset with pins toggling, then release with pins at their idle levels.
        for (int i = 0; i < 3; i++) begin
            sclk_in = 1'($urandom_range(1, 0));
            cs_n_in = 1'($urandom_range(1, 0));
            mosi_in = 1'($urandom_range(1, 0));
            tick(1);
        end
        sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_data_out", 32'(parallel_data_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_miso", 32'(miso_out), 32'h0);
        tick(20);
        check("rst_no_done", 32'(done_seen), 32'h0);

        // MSB first, sample on rise.
        d0 = done_seen;
        start_frame(1'b0, 1'b0, 8'hA5);
        miso_log.delete();
        send_word(8'h3C, W, 1'b0, 10, -1, '0);
        end_frame(10);
        check("msb_data_out", 32'(parallel_data_out), 32'h3C);
        check("msb_done_count", 32'(done_seen - d0), 32'h1);
        check("msb_done_latency", 32'(last_done_cyc - last_rise_cyc), 32'(LAT));
        check("msb_miso_seq", 32'(pack_log()), 32'h00A5);

        // LSB first, sample on fall.
        d0 = done_seen;
        start_frame(1'b1, 1'b1, 8'h01);
        miso_log.delete();
        send_word(8'h80, W, 1'b1, 10, -1, '0);
        end_frame(10);
        check("lsb_data_out", 32'(parallel_data_out), 32'h80);
        check("lsb_done_count", 32'(done_seen - d0), 32'h1);
        check("lsb_miso_seq", 32'(pack_log()), 32'h0080);

        // Complete 0x3C, then abort after 5 bits of 0xFF.
        start_frame(1'b0, 1'b0, 8'h00);
        send_word(8'h3C, W, 1'b0, 10, -1, '0);
        end_frame(10);
        d0 = done_seen;
        start_frame(1'b0, 1'b0, 8'h00);
        send_word(8'hFF, 5, 1'b0, 10, -1, '0);
        end_frame(10);
        check("abort_data_out", 32'(parallel_data_out), 32'h3C);
        check("abort_no_done", 32'(done_seen - d0), 32'h0);
        check("abort_bit_count", 32'(bit_count), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);

        // Back-to-back words under one chip select.
        d0 = done_seen;
        start_frame(1'b0, 1'b0, 8'h5A);
        miso_log.delete();
        send_word(8'h12, W, 1'b0, 10, -1, '0);
        check("b2b_first_word", 32'(parallel_data_out), 32'h12);
        send_word(8'h34, W, 1'b0, 10, -1, '0);
        end_frame(10);
        check("b2b_second_word", 32'(parallel_data_out), 32'h34);
        check("b2b_done_count", 32'(done_seen - d0), 32'h2);
        check("b2b_miso_seq", 32'(pack_log()), 32'h5A5A);

        // Load while active is rejected; load in IDLE is taken.
        l0 = lerr_seen;
        start_frame(1'b0, 1'b0, 8'h96);
        miso_log.delete();
        send_word(8'h00, W, 1'b0, 10, 3, 8'hFF);
        end_frame(10);
        check("active_load_err", 32'(lerr_seen - l0), 32'h1);
        check("active_load_miso", 32'(pack_log()), 32'h0096);
        do_load(8'hFF);
        tick(2);
        check("idle_load_no_err", 32'(lerr_seen - l0), 32'h1);
        check("idle_load_miso", 32'(miso_out), 32'h1);
        do_load(8'h80);
        lsb_first = 1'b0; tick(1);
        check("idle_live_msb", 32'(miso_out), 32'h1);
        lsb_first = 1'b1; tick(1);
        check("idle_live_lsb", 32'(miso_out), 32'h0);

        // Completion and cs_n rise land in the same cycle.
        d0 = done_seen;
        start_frame(1'b0, 1'b0, 8'hC3);
        send_word(8'hB7, W - 1, 1'b0, 10, -1, '0);
        tick(2);
        mosi_in = 1'b1;
        tick(8);
        set_sclk(1'b1);
        set_cs(1'b1);
        tick(10);
        set_sclk(1'b0);
        tick(12);
        check("tie_done_count", 32'(done_seen - d0), 32'h1);
        check("tie_data_out", 32'(parallel_data_out), 32'hB7);
        check("tie_busy", 32'(busy), 32'h0);

        // Reset in the middle of a frame.
        d0 = done_seen;
        start_frame(1'b0, 1'b0, 8'h77);
        send_word(8'hE1, 3, 1'b0, 10, -1, '0);
        reset = 1'b1;
        sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        check("midrst_no_done", 32'(done_seen - d0), 32'h0);
        check("midrst_data_out", 32'(parallel_data_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);

        // Randomised frames.
        for (int f = 0; f < 30; f++) begin
            lsb = 1'($urandom_range(1, 0));
            sf  = 1'($urandom_range(1, 0));
            txw = W'($urandom);
            hp  = int'($urandom_range(12, 6));
            nw  = int'($urandom_range(2, 1));
            start_frame(lsb, sf, txw);
            if ($urandom_range(3, 0) == 0) begin
                lsb_first = ~lsb_first;
                sample_falling = ~sample_falling;
            end
            for (int w = 0; w < nw; w++) begin
                nb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(W - 1, 1)) : W;
                bad_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1;
                rw = W'($urandom);
                bw = W'($urandom);
                send_word(rw, nb, lsb, hp, bad_at, bw);
                if (nb != W) break;
            end
            end_frame(hp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
